// File: rtl/space_bg_scroll_ctrl.sv
// Horizontal scroll controller for the space background ROM.
// Keeps a per-frame scroll offset and turns VGA pixel coordinates into
// wrapped ROM addresses. The visible flag travels alongside the ROM read,
// so bg_rgb and sp_bg_on come out aligned, 3 clocks after x/y.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | scrolling disabled, offset held at 0
// RUN   | offset advances by speed on every frame_tick
// PAUSE | offset frozen, scrolling still enabled
module space_bg_scroll_ctrl #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int SPEED_W = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               video_on,
    input  logic               frame_tick,
    input  logic               run,
    input  logic               pause,
    input  logic [SPEED_W-1:0] speed,
    output logic [8:0]         rom_row,
    output logic [9:0]         rom_col,
    input  logic [11:0]        rom_rgb,
    output logic [11:0]        bg_rgb,
    output logic               sp_bg_on,
    output logic [9:0]         scroll_x,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [10:0] IMG_W11 = 11'(IMG_W);
    localparam logic [9:0]  IMG_W10 = 10'(IMG_W);
    localparam logic [9:0]  IMG_H10 = 10'(IMG_H);

    state_t      state_q;
    state_t      state_nxt;
    logic [9:0]  scroll_q;
    logic [9:0]  scroll_nxt;
    logic [10:0] step_sum;
    logic [10:0] col_sum;
    logic [9:0]  col_wrap;
    logic        x_in;
    logic        y_in;
    logic        v1;
    logic        v2;

    // State register and scroll offset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            scroll_q <= '0;
        end else begin
            state_q  <= state_nxt;
            scroll_q <= scroll_nxt;
        end
    end

    // Next-state logic; run=0 overrides pause from every state.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (run) state_nxt = RUN;
            RUN:     if (!run) state_nxt = IDLE;
                     else if (pause) state_nxt = PAUSE;
            PAUSE:   if (!run) state_nxt = IDLE;
                     else if (!pause) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Offset advances only on a frame_tick while staying in RUN, so it never
    // moves inside the visible part of a frame.
    always_comb begin
        step_sum   = {1'b0, scroll_q} + 11'(speed);
        scroll_nxt = scroll_q;
        if (state_nxt == IDLE) begin
            scroll_nxt = '0;
        end else if (state_q == RUN && state_nxt == RUN && frame_tick) begin
            scroll_nxt = (step_sum >= IMG_W11) ? 10'(step_sum - IMG_W11) : step_sum[9:0];
        end
    end

    // Column wrap: both operands are below IMG_W, so one subtract suffices.
    always_comb begin
        x_in     = (x < IMG_W10);
        y_in     = (y < IMG_H10);
        col_sum  = {1'b0, x} + {1'b0, scroll_q};
        col_wrap = (col_sum >= IMG_W11) ? 10'(col_sum - IMG_W11) : col_sum[9:0];
    end

    // Address stage, ROM-wait stage and output stage of the pixel pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_row  <= '0;
            rom_col  <= '0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            bg_rgb   <= '0;
            sp_bg_on <= 1'b0;
        end else begin
            rom_col  <= x_in ? col_wrap : 10'd0;
            rom_row  <= y_in ? y[8:0] : 9'd0;
            v1       <= video_on & x_in & y_in;
            v2       <= v1;
            bg_rgb   <= v2 ? rom_rgb : 12'd0;
            sp_bg_on <= v2 & (rom_rgb != 12'd0);
        end
    end

    assign scroll_x = scroll_q;
    assign state    = state_q;

endmodule

// File: doc/space_bg_scroll_ctrl.md
Name: space_bg_scroll_ctrl

Overview:
Controls horizontal scrolling of the space background image stored in a synchronous ROM (1-cycle read latency, 12-bit RGB, 9-bit row / 10-bit col address).
- Holds a per-frame scroll offset advanced by a programmable speed.
- Maps the VGA pixel coordinate to a wrapped ROM address.
- Pipelines video_on alongside the ROM read, so the background RGB and its on-flag arrive aligned.
- Sits between the vga_sync circuit, the background ROM and the pixel colour mux.

Parameters:
IMG_W, 640, image width in pixels; wrap modulus for column address (must be <= 1023)
IMG_H, 480, image height in rows; rows >= IMG_H address row 0
SPEED_W, 3, width of the speed input (pixels per frame)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
x  in  10  current pixel column from vga_sync
y  in  10  current pixel row from vga_sync
video_on  in  1  visible-area flag from vga_sync, aligned with x/y
frame_tick  in  1  one-cycle pulse at start of vertical blank
run  in  1  level; 1 = scrolling enabled, 0 = return to IDLE
pause  in  1  level; 1 = freeze offset while running
speed  in  SPEED_W  offset increment per frame_tick
rom_row  out  9  ROM row address (registered)
rom_col  out  10  ROM column address (registered)
rom_rgb  in  12  ROM data, valid one cycle after address
bg_rgb  out  12  background colour (registered)
sp_bg_on  out  1  1 when bg_rgb != 0 and pixel visible (registered)
scroll_x  out  10  current scroll offset
state  out  2  00 IDLE, 01 RUN, 10 PAUSE

Behaviour:
Reset (reset_n low, async):
- state=IDLE; scroll_x=0; rom_row=0; rom_col=0; bg_rgb=0; sp_bg_on=0; pipeline valid flags cleared.
- Effect is immediate and applies mid-frame.
- First update after release occurs on the next clk edge.

State machine (evaluated every clk edge):
- IDLE: scroll_x forced to 0. Go to RUN when run=1.
- RUN: go to IDLE when run=0. Otherwise go to PAUSE when pause=1.
- PAUSE: go to IDLE when run=0. Otherwise go to RUN when pause=0.
- run=0 has priority over pause in every state.

Offset update:
- Only in state RUN, on a cycle with frame_tick=1 and no transition out of RUN on that edge.
- scroll_x <= (scroll_x + speed) mod IMG_W, computed 11 bits wide; subtract IMG_W once if the sum is >= IMG_W.
- speed=0: offset held.
- frame_tick in PAUSE or IDLE: no change.
- frame_tick on the same cycle run falls: IDLE wins, scroll_x=0.
- The offset never changes except on frame_tick, so there is no tearing within a frame.

Address pipeline (stage 1, cycle n+1 for pixel at cycle n):
- rom_col <= (x + scroll_x) mod IMG_W, computed 11 bits wide with a single conditional subtract.
- This requires x < IMG_W; for x >= IMG_W, rom_col <= 0.
- rom_row <= (y < IMG_H) ? y[8:0] : 0.
- v1 <= video_on & (x < IMG_W) & (y < IMG_H).

ROM stage (cycle n+2):
- rom_rgb valid; v2 <= v1.

Output stage (cycle n+3):
- bg_rgb <= v2 ? rom_rgb : 0.
- sp_bg_on <= v2 & (rom_rgb != 0).
- Total latency from x/y to bg_rgb/sp_bg_on is exactly 3 clocks; the pixel mux must delay the other layers to match.

Test Plan:
- Reset then run=1, speed=3, five frame_tick pulses -> state=01, scroll_x=15; rom_col for x=0 equals 15 one clock later.
- scroll_x=638, speed=5, frame_tick -> scroll_x=3. With x=639, scroll_x=3: rom_col=2 (wrap); x=636: rom_col=639.
- pause=1 then three frame_ticks -> state=10, scroll_x unchanged. pause=0 -> state=01 next edge; next tick adds speed.
- run falls on the same cycle as frame_tick with scroll_x=100 -> state=00, scroll_x=0; later ticks do not move it.
- Pixel pipeline: drive x=10, y=20, video_on=1, ROM model returning 12'hF0A for (row 20, col 10+scroll_x) -> bg_rgb=F0A and sp_bg_on=1 exactly 3 clocks later. Same pixel with video_on=0 -> bg_rgb=0, sp_bg_on=0. rom_rgb=0 -> sp_bg_on=0.
- reset_n asserted mid-line while running (scroll_x=200) -> all outputs 0 immediately without a clock edge; after release, state=IDLE until run is sampled high.
